// File: rtl/step_pkg.sv
// Shared step-pulse definitions: state encoding, the one-second constant and the rate ceiling.
// Latency: none (types, constants and a constant function only).
// Backpressure: none.
package step_pkg;

   // One second in clock cycles. The step counters use the same value,
   // so the generator and the counters always agree on what a second is.
   localparam int STEP_CLK_HZ = 1000;

   // Run-control states of the pulse generator
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } step_state_e;

   // Highest rate that still leaves at least PULSE_W low cycles between
   // pulses and lets the last pulse of a second fall before the boundary.
   function automatic int max_rate(input int clk_hz, input int pulse_w);
      return clk_hz / (2 * pulse_w);
   endfunction

endpackage

// File: rtl/step_rate_accum.sv
// Phase accumulator that spaces pulse launches evenly across a second, plus a PULSE_W stretcher.
// Latency: launch is combinational in the launch cycle; pulse rises one cycle later for PULSE_W cycles.
// Backpressure: none; dropping run clears the stretcher so pulse is low on the next cycle.
module step_rate_accum import step_pkg::*; #(
   parameter int CLK_HZ  = STEP_CLK_HZ,
   parameter int PULSE_W = 4,
   parameter int ACC_W   = $clog2(2 * CLK_HZ)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             init,
   input  logic             run,
   input  logic             sec_end,
   input  logic [ACC_W-1:0] rate,
   output logic             launch,
   output logic             pulse
);

   localparam int               REM_W = $clog2(PULSE_W + 1);
   localparam logic [ACC_W-1:0] HZ    = ACC_W'(CLK_HZ);
   localparam logic [REM_W-1:0] WIDTH = REM_W'(PULSE_W);
   localparam logic [REM_W-1:0] ONE   = REM_W'(1);

   logic [ACC_W-1:0] acc;
   logic [ACC_W-1:0] acc_sum;
   logic [REM_W-1:0] rem;

   // Launch whenever the accumulated phase crosses one second's worth of counts.
   // Seeding acc with CLK_HZ - rate makes the very first cycle of a second launch.
   always_comb begin
      acc_sum = acc + rate;
      launch  = run && (rate != '0) && (acc_sum >= HZ);
   end

   // Phase accumulator; re-seeded at start and at every second boundary so each
   // second carries exactly 'rate' launches with no drift between seconds.
   always_ff @(posedge clk) begin
      if (rst) begin
         acc <= '0;
      end else if (init) begin
         acc <= HZ - rate;
      end else if (run) begin
         if (sec_end) begin
            acc <= HZ - rate;
         end else if (launch) begin
            acc <= acc_sum - HZ;
         end else begin
            acc <= acc_sum;
         end
      end
   end

   // Width stretcher: a launch holds pulse high for the next PULSE_W cycles;
   // any cycle without run (stop, idle, done) truncates an in-flight pulse.
   always_ff @(posedge clk) begin
      if (rst || !run) begin
         rem   <= '0;
         pulse <= 1'b0;
      end else if (launch) begin
         rem   <= WIDTH;
         pulse <= 1'b1;
      end else if (rem > ONE) begin
         rem   <= rem - ONE;
         pulse <= 1'b1;
      end else begin
         rem   <= '0;
         pulse <= 1'b0;
      end
   end

endmodule

// File: rtl/step_pulse_gen.sv
// Step-pulse transmitter: rate steps/second for num_secs seconds, with start/busy/done handshake.
// Latency: busy rises one cycle after start is sampled; first Pulse one cycle after that.
// Backpressure: start is ignored unless IDLE; stop aborts a run with Pulse low on the next cycle.
module step_pulse_gen import step_pkg::*; #(
   parameter int CLK_HZ  = STEP_CLK_HZ,
   parameter int PULSE_W = 4,
   parameter int RATE_W  = 7,
   parameter int SECS_W  = 4,
   parameter int CNT_W   = 12
) (
   input  logic              CLK,
   input  logic              RESET,
   input  logic              start,
   input  logic              stop,
   input  logic [RATE_W-1:0] rate,
   input  logic [SECS_W-1:0] num_secs,
   output logic              Pulse,
   output logic              busy,
   output logic              done,
   output logic              sec_tick,
   output logic [CNT_W-1:0]  pulse_count
);

   localparam int              MAX_RATE = max_rate(CLK_HZ, PULSE_W);
   localparam int              ACC_W    = $clog2(2 * CLK_HZ);
   localparam int              SC_W     = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
   localparam logic [SC_W-1:0] SEC_LAST = SC_W'(CLK_HZ - 1);

   step_state_e       state;
   step_state_e       state_nxt;
   logic [ACC_W-1:0]  rate_clamped;
   logic [ACC_W-1:0]  rate_q;
   logic [ACC_W-1:0]  rate_use;
   logic [SECS_W-1:0] secs_q;
   logic [SECS_W-1:0] sec_num;
   logic [SECS_W-1:0] sec_num_nxt;
   logic [SC_W-1:0]   sec_cyc;
   logic [SC_W-1:0]   sec_cyc_nxt;
   logic              accept;
   logic              running;
   logic              advance;
   logic              sec_end;
   logic              last_sec;
   logic              launch;

   // Clamp the requested rate so pulses never overlap or straddle a second boundary.
   always_comb begin
      if (32'(rate) > 32'(MAX_RATE)) begin
         rate_clamped = ACC_W'(MAX_RATE);
      end else begin
         rate_clamped = ACC_W'(rate);
      end
   end

   // Run-control decode. A stop cycle does not advance the accumulator, so
   // nothing launches in the cycle that ends the run.
   always_comb begin
      accept   = (state == IDLE) && start;
      running  = (state == RUN);
      advance  = running && !stop;
      sec_end  = running && (sec_cyc == SEC_LAST);
      last_sec = (({1'b0, sec_num} + (SECS_W + 1)'(1)) == {1'b0, secs_q});
      rate_use = accept ? rate_clamped : rate_q;
   end

   // Next state and second/cycle counters. A zero-rate run still lasts its
   // seconds; only a zero-length run skips RUN. stop beats a boundary.
   always_comb begin
      state_nxt   = state;
      sec_cyc_nxt = sec_cyc;
      sec_num_nxt = sec_num;
      case (state)
         IDLE: begin
            if (start) begin
               state_nxt   = (num_secs == '0) ? DONE : RUN;
               sec_cyc_nxt = '0;
               sec_num_nxt = '0;
            end
         end
         RUN: begin
            if (sec_end) begin
               sec_cyc_nxt = '0;
               sec_num_nxt = sec_num + SECS_W'(1);
            end else begin
               sec_cyc_nxt = sec_cyc + SC_W'(1);
            end
            if (stop || (sec_end && last_sec)) begin
               state_nxt = DONE;
            end
         end
         DONE: begin
            state_nxt = IDLE;
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase
   end

   // State, counters and the run parameters captured when start is accepted.
   always_ff @(posedge CLK) begin
      if (RESET) begin
         state   <= IDLE;
         sec_cyc <= '0;
         sec_num <= '0;
         secs_q  <= '0;
         rate_q  <= '0;
      end else begin
         state   <= state_nxt;
         sec_cyc <= sec_cyc_nxt;
         sec_num <= sec_num_nxt;
         if (accept) begin
            rate_q <= rate_clamped;
            secs_q <= num_secs;
         end
      end
   end

   // Status outputs registered from next-state values so they line up with the state they describe.
   always_ff @(posedge CLK) begin
      if (RESET) begin
         busy     <= 1'b0;
         done     <= 1'b0;
         sec_tick <= 1'b0;
      end else begin
         busy     <= (state_nxt == RUN);
         done     <= (state_nxt == DONE);
         sec_tick <= (state_nxt == RUN) && (sec_cyc_nxt == SEC_LAST);
      end
   end

   // Launches since the last accepted start, holding at all-ones.
   always_ff @(posedge CLK) begin
      if (RESET) begin
         pulse_count <= '0;
      end else if (accept) begin
         pulse_count <= '0;
      end else if (launch && (pulse_count != '1)) begin
         pulse_count <= pulse_count + CNT_W'(1);
      end
   end

   step_rate_accum #(
      .CLK_HZ  (CLK_HZ),
      .PULSE_W (PULSE_W),
      .ACC_W   (ACC_W)
   ) u_accum (
      .clk     (CLK),
      .rst     (RESET),
      .init    (accept),
      .run     (advance),
      .sec_end (sec_end),
      .rate    (rate_use),
      .launch  (launch),
      .pulse   (Pulse)
   );

endmodule
